// File: rtl/load_return_queue.sv
// load_return_queue
// ------------------
// Purpose: read-side counterpart of the store byte-lane formatter. Load
// descriptors issued by the MEM stage are queued in order. Each in-order
// data-bus read response is paired with the oldest descriptor. The addressed
// byte, halfword or word is extracted and sign- or zero-extended. For LWL/LWR
// the memory bytes are merged into the old register value instead. The
// result is presented through a registered valid/ready output to writeback.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  load descriptor offered
//   req_ready  queue can accept a descriptor
//   req_addr   byte offset addr[1:0]
//   req_size   11 word, 10 unaligned word (LWL/LWR), 01 half, 00 byte
//   req_sign   1 sign-extend, 0 zero-extend
//   req_alr    bit 0: 1 LWL, 0 LWR (only meaningful when size = 10)
//   req_old    current rt value for the LWL/LWR merge
//   req_wreg   destination register
//   rsp_valid  bus read data valid
//   rsp_ready  response accepted this cycle
//   rsp_rdata  raw aligned bus word
//   out_valid  writeback result valid
//   out_ready  writeback consumer ready
//   out_data   formatted load result
//   out_wreg   destination register of the result
//   pending    descriptors queued and not yet answered
module load_return_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_sign,
  input  logic [1:0]    req_alr,
  input  logic [31:0]   req_old,
  input  logic [4:0]    req_wreg,
  input  logic          rsp_valid,
  output logic          rsp_ready,
  input  logic [31:0]   rsp_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [4:0]    out_wreg,
  output logic [CW-1:0] pending
);

  localparam int AW = $clog2(DEPTH);

  // Descriptor storage, one array per field, indexed by the ring pointers.
  logic [1:0]    r_qAddr [DEPTH];
  logic [1:0]    r_qSize [DEPTH];
  logic          r_qSign [DEPTH];
  logic          r_qLwl  [DEPTH];
  logic [31:0]   r_qOld  [DEPTH];
  logic [4:0]    r_qWreg [DEPTH];

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic          r_outValid;
  logic [31:0]   r_outData;
  logic [4:0]    r_outWreg;

  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_result;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  logic [4:0]    w_lwlShift;
  logic [4:0]    w_lwrShift;
  logic [1:0]    w_hAddr;
  logic [1:0]    w_hSize;
  logic          w_hSign;
  logic          w_hLwl;
  logic [31:0]   w_hOld;
  logic          w_unused;

  // Only alr[0] distinguishes LWL from LWR; the upper bit carries no meaning here.
  assign w_unused = req_alr[1];

  // Handshakes. Ready for a push looks only at the registered count, so a
  // pop in the same cycle never frees a slot for the incoming descriptor.
  // A response is taken only when a descriptor is queued and the output
  // register is free or being drained this cycle.
  assign req_ready = (r_count != CW'(DEPTH));
  assign rsp_ready = (r_count != '0) && (!r_outValid || out_ready);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;

  assign pending   = r_count;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_wreg  = r_outWreg;

  // Descriptor payload write. The storage itself needs no reset because the
  // count and pointers decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qAddr[r_wrPtr] <= req_addr;
      r_qSize[r_wrPtr] <= req_size;
      r_qSign[r_wrPtr] <= req_sign;
      r_qLwl[r_wrPtr]  <= req_alr[0];
      r_qOld[r_wrPtr]  <= req_old;
      r_qWreg[r_wrPtr] <= req_wreg;
    end
  end

  // Ring pointers and occupancy count. DEPTH is a power of two, so the
  // pointers wrap naturally. A simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head descriptor fields, as seen by the formatter.
  assign w_hAddr = r_qAddr[r_rdPtr];
  assign w_hSize = r_qSize[r_rdPtr];
  assign w_hSign = r_qSign[r_rdPtr];
  assign w_hLwl  = r_qLwl[r_rdPtr];
  assign w_hOld  = r_qOld[r_rdPtr];

  // LWL shifts left by 8*(3-a), which for a 2-bit offset is 8*~a.
  // LWR shifts right by 8*a.
  assign w_lwlShift = {~w_hAddr, 3'b000};
  assign w_lwrShift = {w_hAddr, 3'b000};

  // Formatter: selects the addressed lane of the bus word and extends it,
  // or merges memory bytes into the old register value for LWL/LWR.
  always_comb begin
    w_result = '0;
    w_half   = w_hAddr[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    case (w_hAddr)
      2'd0:    w_byte = rsp_rdata[7:0];
      2'd1:    w_byte = rsp_rdata[15:8];
      2'd2:    w_byte = rsp_rdata[23:16];
      default: w_byte = rsp_rdata[31:24];
    endcase
    case (w_hSize)
      2'b11: w_result = rsp_rdata;
      2'b01: w_result = {{16{w_hSign & w_half[15]}}, w_half};
      2'b00: w_result = {{24{w_hSign & w_byte[7]}}, w_byte};
      default: begin
        if (w_hLwl) begin
          w_result = (rsp_rdata << w_lwlShift) |
                     (w_hOld & ~(32'hFFFF_FFFF << w_lwlShift));
        end else begin
          w_result = (rsp_rdata >> w_lwrShift) |
                     (w_hOld & ~(32'hFFFF_FFFF >> w_lwrShift));
        end
      end
    endcase
  end

  // Output register. A pop loads a fresh result. Without a pop, a completed
  // output handshake retires the current result. Otherwise the data holds
  // stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outWreg  <= '0;
    end else if (w_pop) begin
      r_outValid <= 1'b1;
      r_outData  <= w_result;
      r_outWreg  <= r_qWreg[r_rdPtr];
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_return_queue.sv
// tb_load_return_queue
// --------------------
// Scoreboard bench for load_return_queue. Every pushed descriptor is paired
// with the bus word it will be answered with, and with the expected
// formatted result. The expected values come straight from hand-worked
// load semantics. A monitor retires expected results in order whenever the
// output handshakes.
module tb_load_return_queue;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  wreg;
  } expT;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqAddr;
  logic [1:0]  reqSize;
  logic        reqSign;
  logic [1:0]  reqAlr;
  logic [31:0] reqOld;
  logic [4:0]  reqWreg;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [4:0]  outWreg;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;

  expT         sb[$];
  logic [31:0] plan[$];

  load_return_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_ready(reqReady), .req_addr(reqAddr),
    .req_size(reqSize), .req_sign(reqSign), .req_alr(reqAlr),
    .req_old(reqOld), .req_wreg(reqWreg),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_wreg(outWreg), .pending(pending)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Output monitor. It looks at the outputs mid-cycle, when the
  // handshake about to happen at the next edge is already settled. It then
  // retires the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && outValid === 1'b1 && outReady === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_result: got data=%h wreg=%0d, required no result", outData, outWreg);
      end else begin
        expT e;
        e = sb.pop_front();
        if (outData !== e.data || outWreg !== e.wreg) begin
          errors++;
          $display("[TB] FAIL result: got data=%h wreg=%0d, required data=%h wreg=%0d",
                   outData, outWreg, e.data, e.wreg);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one descriptor, waits for acceptance, and records the bus word
  // it will be answered with plus the expected result.
  task automatic pushLoad(input logic [1:0] a, input logic [1:0] sz, input logic sg,
                          input logic [1:0] alr, input logic [31:0] old,
                          input logic [4:0] wreg, input logic [31:0] data,
                          input logic [31:0] expData);
    int t;
    reqAddr = a; reqSize = sz; reqSign = sg; reqAlr = alr;
    reqOld = old; reqWreg = wreg; reqValid = 1'b1;
    #1;
    t = 0;
    while (reqReady !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (reqReady !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: req_ready=%b, required 1", reqReady);
    end else begin
      sb.push_back('{data: expData, wreg: wreg});
      plan.push_back(data);
    end
    tick();
    reqValid = 1'b0;
  endtask

  // Answers n queued descriptors in order. With strict set, every response
  // must be accepted immediately, which is the back-to-back property.
  task automatic respondN(input int n, input bit strict);
    int t;
    for (int k = 0; k < n; k++) begin
      if (plan.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL respond_plan: plan size=0, required >0");
        break;
      end
      rspRdata = plan[0];
      rspValid = 1'b1;
      #1;
      if (strict) begin
        checks++;
        if (rspReady !== 1'b1) begin
          errors++;
          $display("[TB] FAIL back_to_back_rsp_ready: got %b, required 1", rspReady);
        end
      end
      t = 0;
      while (rspReady !== 1'b1 && t < 50) begin
        tick();
        t++;
      end
      if (rspReady !== 1'b1) begin
        checks++;
        errors++;
        $display("[TB] FAIL respond_timeout: rsp_ready=%b, required 1", rspReady);
        break;
      end
      tick();
      void'(plan.pop_front());
    end
    rspValid = 1'b0;
  endtask

  // Lets the output drain, then checks the queue and scoreboard are empty.
  task automatic checkDrained(input string name);
    tick();
    tick();
    checks++;
    if (pending !== 3'd0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drained: pending=%0d outstanding=%0d, required 0 and 0",
               name, pending, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; reqValid = 1'b0; rspValid = 1'b0; outReady = 1'b0;
    reqAddr = '0; reqSize = '0; reqSign = 1'b0; reqAlr = '0;
    reqOld = '0; reqWreg = '0; rspRdata = '0;
    tick();
    tick();
    checks++;
    if (pending !== 3'd0 || outValid !== 1'b0 || outData !== 32'h0 || outWreg !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: pending=%0d out_valid=%b out_data=%h out_wreg=%0d, required 0 0 0 0",
               pending, outValid, outData, outWreg);
    end
    checks++;
    if (reqReady !== 1'b1 || rspReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: req_ready=%b rsp_ready=%b, required 1 0", reqReady, rspReady);
    end
    rst = 1'b0;
    outReady = 1'b1;
    tick();
  endtask

  task automatic test_byte_loads();
    // LB at each offset.
    pushLoad(2'd0, 2'b00, 1'b1, 2'b00, 32'h0, 5'd1, 32'h80FF7F01, 32'h00000001);
    pushLoad(2'd1, 2'b00, 1'b1, 2'b00, 32'h0, 5'd2, 32'h80FF7F01, 32'h0000007F);
    pushLoad(2'd2, 2'b00, 1'b1, 2'b00, 32'h0, 5'd3, 32'h80FF7F01, 32'hFFFFFFFF);
    pushLoad(2'd3, 2'b00, 1'b1, 2'b00, 32'h0, 5'd4, 32'h80FF7F01, 32'hFFFFFF80);
    respondN(4, 1'b1);
    // LBU at each offset.
    pushLoad(2'd0, 2'b00, 1'b0, 2'b00, 32'h0, 5'd5, 32'h80FF7F01, 32'h00000001);
    pushLoad(2'd1, 2'b00, 1'b0, 2'b00, 32'h0, 5'd6, 32'h80FF7F01, 32'h0000007F);
    pushLoad(2'd2, 2'b00, 1'b0, 2'b00, 32'h0, 5'd7, 32'h80FF7F01, 32'h000000FF);
    pushLoad(2'd3, 2'b00, 1'b0, 2'b00, 32'h0, 5'd8, 32'h80FF7F01, 32'h00000080);
    respondN(4, 1'b1);
    checkDrained("byte");
  endtask

  task automatic test_half_loads();
    pushLoad(2'd2, 2'b01, 1'b1, 2'b00, 32'h0, 5'd9,  32'h80011234, 32'hFFFF8001);
    pushLoad(2'd0, 2'b01, 1'b0, 2'b00, 32'h0, 5'd10, 32'h80011234, 32'h00001234);
    pushLoad(2'd0, 2'b01, 1'b1, 2'b00, 32'h0, 5'd11, 32'h80011234, 32'h00001234);
    pushLoad(2'd3, 2'b01, 1'b0, 2'b00, 32'h0, 5'd12, 32'h80011234, 32'h00008001);
    respondN(4, 1'b1);
    checkDrained("half");
  endtask

  task automatic test_merge_loads();
    pushLoad(2'd0, 2'b10, 1'b0, 2'b01, 32'hAABBCCDD, 5'd13, 32'h11223344, 32'h44BBCCDD);
    pushLoad(2'd3, 2'b10, 1'b0, 2'b01, 32'hAABBCCDD, 5'd14, 32'h11223344, 32'h11223344);
    pushLoad(2'd1, 2'b10, 1'b0, 2'b11, 32'hAABBCCDD, 5'd15, 32'h11223344, 32'h3344CCDD);
    pushLoad(2'd2, 2'b10, 1'b0, 2'b01, 32'hAABBCCDD, 5'd16, 32'h11223344, 32'h223344DD);
    respondN(4, 1'b1);
    pushLoad(2'd0, 2'b10, 1'b0, 2'b00, 32'hAABBCCDD, 5'd17, 32'h11223344, 32'h11223344);
    pushLoad(2'd3, 2'b10, 1'b0, 2'b00, 32'hAABBCCDD, 5'd18, 32'h11223344, 32'hAABBCC11);
    pushLoad(2'd1, 2'b10, 1'b0, 2'b10, 32'hAABBCCDD, 5'd19, 32'h11223344, 32'hAA112233);
    pushLoad(2'd2, 2'b10, 1'b0, 2'b00, 32'hAABBCCDD, 5'd20, 32'h11223344, 32'hAABB1122);
    respondN(4, 1'b1);
    checkDrained("merge");
  endtask

  task automatic test_full_queue();
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd21, 32'h10000001, 32'h10000001);
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd22, 32'h20000002, 32'h20000002);
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd23, 32'h30000003, 32'h30000003);
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd24, 32'h40000004, 32'h40000004);
    checks++;
    if (pending !== 3'd4 || reqReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_state: pending=%0d req_ready=%b, required 4 0", pending, reqReady);
    end
    // Offer a push and a response together; only the response may land.
    reqAddr = 2'd0; reqSize = 2'b11; reqSign = 1'b0; reqAlr = 2'b00;
    reqOld = 32'h0; reqWreg = 5'd25; reqValid = 1'b1;
    rspRdata = plan[0]; rspValid = 1'b1;
    #1;
    checks++;
    if (rspReady !== 1'b1 || reqReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_simul: rsp_ready=%b req_ready=%b, required 1 0", rspReady, reqReady);
    end
    tick();
    void'(plan.pop_front());
    reqValid = 1'b0;
    rspValid = 1'b0;
    #1;
    checks++;
    if (reqReady !== 1'b1 || pending !== 3'd3) begin
      errors++;
      $display("[TB] FAIL full_after: req_ready=%b pending=%0d, required 1 3", reqReady, pending);
    end
    checks++;
    if (outValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_latency: out_valid=%b, required 1", outValid);
    end
    respondN(3, 1'b1);
    checkDrained("full");
  endtask

  task automatic test_output_stall();
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd26, 32'hA5A50001, 32'hA5A50001);
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd27, 32'hA5A50002, 32'hA5A50002);
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd28, 32'hA5A50003, 32'hA5A50003);
    outReady = 1'b0;
    respondN(1, 1'b1);
    // Keep the next response pending throughout the stall.
    rspRdata = plan[0];
    rspValid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (outValid !== 1'b1 || outData !== 32'hA5A50001 || outWreg !== 5'd26) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%b data=%h wreg=%0d, required 1 a5a50001 26",
                 c, outValid, outData, outWreg);
      end
      checks++;
      if (rspReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_rsp_ready[%0d]: got %b, required 0", c, rspReady);
      end
      tick();
    end
    checks++;
    if (pending !== 3'd2) begin
      errors++;
      $display("[TB] FAIL stall_pending: got %0d, required 2", pending);
    end
    outReady = 1'b1;
    respondN(2, 1'b1);
    checkDrained("stall");
  endtask

  task automatic test_reset_midflight();
    outReady = 1'b0;
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd29, 32'hDEAD0001, 32'hDEAD0001);
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd30, 32'hDEAD0002, 32'hDEAD0002);
    pushLoad(2'd0, 2'b11, 1'b0, 2'b00, 32'h0, 5'd31, 32'hDEAD0003, 32'hDEAD0003);
    respondN(1, 1'b1);
    checks++;
    if (pending !== 3'd2 || outValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: pending=%0d out_valid=%b, required 2 1", pending, outValid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    plan.delete();
    checks++;
    if (pending !== 3'd0 || outValid !== 1'b0 || outData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: pending=%0d out_valid=%b out_data=%h, required 0 0 0",
               pending, outValid, outData);
    end
    rspRdata = 32'hBAD0BAD0;
    rspValid = 1'b1;
    #1;
    checks++;
    if (rspReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_rsp_ready: got %b, required 0", rspReady);
    end
    tick();
    rspValid = 1'b0;
    checks++;
    if (outValid !== 1'b0 || pending !== 3'd0) begin
      errors++;
      $display("[TB] FAIL empty_rsp_effect: out_valid=%b pending=%0d, required 0 0", outValid, pending);
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_byte_loads();
    test_half_loads();
    test_merge_loads();
    test_full_queue();
    test_output_stall();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
